// File: rtl/restoring_divider8_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package restoring_divider8_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_divider8_sub_borrow_n.sv
// Combinational WIDTH-bit a - b with borrow out, built from chained 4-bit
// nibble subtractor stages (ripple borrow between nibbles).
module sub_borrow_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NIB = WIDTH / 4;

  logic [NIB:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < NIB; i++) begin : g_nib
    logic [4:0] t;
    // Bit 4 of the 5-bit difference is the nibble's borrow out.
    assign t = {1'b0, a[4*i+3 -: 4]} - {1'b0, b[4*i+3 -: 4]} - {4'b0, borrow[i]};
    assign diff[4*i+3 -: 4] = t[3:0];
    assign borrow[i+1]      = t[4];
  end

  assign bout = borrow[NIB];

endmodule

// File: rtl/restoring_divider8.sv
// Sequential unsigned restoring divider: one shift-and-trial-subtract per clock,
// quotient/remainder registered on completion with a one-cycle done pulse.
module restoring_divider8
  import restoring_divider8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] r_work, q_work, d_work;
  logic [CW-1:0]    iter;
  logic             accept, zero_div, last;
  logic [WIDTH-1:0] s_low, diff;
  logic             bout, eff_borrow;

  assign accept   = start && (state != RUN);
  assign zero_div = (divisor == '0);
  assign last     = (state == RUN) && (iter == CW'(WIDTH));

  // Trial operand is {r_work, q_work msb}; its top bit is r_work msb, and when
  // set the shifted remainder already exceeds any divisor.
  assign s_low      = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
  assign eff_borrow = bout && !r_work[WIDTH-1];

  sub_borrow_n #(.WIDTH(WIDTH)) u_sub (
    .a    (s_low),
    .b    (d_work),
    .diff (diff),
    .bout (bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = zero_div ? DONE : RUN;
        else        state_nx = IDLE;
      end
      RUN:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work      <= '0;
      q_work      <= '0;
      d_work      <= '0;
      iter        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept && !zero_div) begin
        r_work <= '0;
        q_work <= dividend;
        d_work <= divisor;
        iter   <= '0;
      end else if (state == RUN && !last) begin
        r_work <= eff_borrow ? s_low : diff;
        q_work <= {q_work[WIDTH-2:0], !eff_borrow};
        iter   <= iter + CW'(1);
      end

      if (accept && zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (last) begin
        quotient    <= q_work;
        remainder   <= r_work;
        div_by_zero <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN) && !last;
  assign done = (state == DONE);

endmodule
